// File: rtl/multiply_tokens.sv
// Token multiplier: each input pulse on a owes FACTOR output pulses on b,
// emitted at most one per cycle under b_ready, with a saturating backlog.
module multiply_tokens #(
   parameter int FACTOR      = 2,
   parameter int MAX_BACKLOG = 200,
   localparam int CNT_W      = $clog2(MAX_BACKLOG + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a,
   input  logic             b_ready,
   output logic             b,
   output logic [CNT_W-1:0] backlog,
   output logic             overflow
);

   // Three spare bits cover the worst-case transient of a full backlog plus FACTOR.
   localparam int SUM_W = CNT_W + 3;

   logic [CNT_W-1:0] cnt;
   logic [SUM_W-1:0] sum;
   logic             sat;

   // First owed token of a fresh input may leave in the same cycle it arrives.
   assign b = rst & b_ready & ((cnt != '0) | a);

   always_comb begin
      sum = SUM_W'(cnt) + (a ? SUM_W'(FACTOR) : '0) - SUM_W'(b);
      sat = (sum > SUM_W'(MAX_BACKLOG));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (sat) begin
            cnt      <= CNT_W'(MAX_BACKLOG);
            overflow <= 1'b1;
         end else begin
            cnt <= sum[CNT_W-1:0];
         end
      end
   end

   assign backlog = cnt;

endmodule

// File: tb/tb_multiply_tokens.sv
// Directed and random checks of multiply_tokens at FACTOR=2 and FACTOR=3
// against an integer token-accounting model.
module tb_multiply_tokens;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a = 1'b0, b_ready = 1'b0;
   logic       a3 = 1'b0, b_ready3 = 1'b0;
   logic       b, b3, overflow, overflow3;
   logic [7:0] backlog, backlog3;

   int errors = 0;
   int checks = 0;
   int m_owed = 0;
   int m_ovf = 0;
   int m3_owed = 0;
   int m3_ovf = 0;

   always #5 clk = ~clk;

   multiply_tokens dut (
      .clk(clk), .rst(rst), .a(a), .b_ready(b_ready),
      .b(b), .backlog(backlog), .overflow(overflow)
   );

   multiply_tokens #(.FACTOR(3)) dut3 (
      .clk(clk), .rst(rst), .a(a3), .b_ready(b_ready3),
      .b(b3), .backlog(backlog3), .overflow(overflow3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock of the FACTOR=2 instance; model owes 2 per token, pays 1 per b.
   task automatic step(input logic av, input logic brv, output logic bo);
      int eb;
      @(negedge clk);
      a = av; b_ready = brv;
      #1;
      eb = (brv && (m_owed > 0 || av)) ? 1 : 0;
      bo = b;
      check("b", {31'b0, b}, eb);
      @(posedge clk);
      #1;
      m_owed = m_owed + (av ? 2 : 0) - eb;
      if (m_owed > 200) begin
         m_owed = 200;
         m_ovf  = 1;
      end
      check("backlog", {24'b0, backlog}, m_owed);
      check("overflow", {31'b0, overflow}, m_ovf);
   endtask

   task automatic step3(input logic av, input logic brv, output logic bo);
      int eb;
      @(negedge clk);
      a3 = av; b_ready3 = brv;
      #1;
      eb = (brv && (m3_owed > 0 || av)) ? 1 : 0;
      bo = b3;
      check("b3", {31'b0, b3}, eb);
      @(posedge clk);
      #1;
      m3_owed = m3_owed + (av ? 3 : 0) - eb;
      if (m3_owed > 200) begin
         m3_owed = 200;
         m3_ovf  = 1;
      end
      check("backlog3", {24'b0, backlog3}, m3_owed);
      check("overflow3", {31'b0, overflow3}, m3_ovf);
   endtask

   initial begin
      logic bo;
      int   nb, na, peak;

      // Reset state: b must stay low even with a and b_ready asserted.
      a = 1'b1; b_ready = 1'b1;
      #2;
      check("rst_b", {31'b0, b}, 0);
      check("rst_backlog", {24'b0, backlog}, 0);
      check("rst_overflow", {31'b0, overflow}, 0);
      check("rst_b3", {31'b0, b3}, 0);
      @(negedge clk);
      a = 1'b0;
      #1 rst = 1'b1;

      // Single token with b_ready high.
      step(1, 1, bo); check("single_t", {31'b0, bo}, 1);
      check("single_backlog_t", {24'b0, backlog}, 1);
      step(0, 1, bo); check("single_t1", {31'b0, bo}, 1);
      check("single_backlog_t1", {24'b0, backlog}, 0);
      step(0, 1, bo); check("single_t2", {31'b0, bo}, 0);

      // Burst of 10 tokens: 20 consecutive b pulses, backlog peaks at 10.
      nb = 0; peak = 0;
      for (int i = 0; i < 25; i++) begin
         step(i < 10, 1, bo);
         if (i < 20) check("burst_b_run", {31'b0, bo}, 1);
         nb += int'(bo);
         if (int'(backlog) > peak) peak = int'(backlog);
      end
      check("burst_count", nb, 20);
      check("burst_peak", peak, 10);
      check("burst_backlog", {24'b0, backlog}, 0);
      check("burst_overflow", {31'b0, overflow}, 0);

      // Backpressure: three isolated tokens, then drain.
      for (int i = 0; i < 9; i++) step((i % 3) == 0, 0, bo);
      check("bp_backlog", {24'b0, backlog}, 6);
      nb = 0;
      for (int i = 0; i < 9; i++) begin
         step(0, 1, bo);
         check(i < 6 ? "bp_drain_on" : "bp_drain_off", {31'b0, bo}, (i < 6) ? 1 : 0);
         nb += int'(bo);
      end
      check("bp_count", nb, 6);

      // Saturation at 200 with b_ready low.
      for (int i = 0; i < 100; i++) step(1, 0, bo);
      check("sat_backlog_100", {24'b0, backlog}, 200);
      check("sat_overflow_100", {31'b0, overflow}, 0);
      step(1, 0, bo);
      check("sat_backlog_101", {24'b0, backlog}, 200);
      check("sat_overflow_101", {31'b0, overflow}, 1);
      nb = 0;
      for (int i = 0; i < 205; i++) begin
         step(0, 1, bo);
         nb += int'(bo);
      end
      check("sat_drain_count", nb, 200);
      check("sat_overflow_sticky", {31'b0, overflow}, 1);

      // Asynchronous reset mid-operation with overflow still set.
      for (int i = 0; i < 3; i++) step(1, 0, bo);
      check("mid_backlog", {24'b0, backlog}, 6);
      @(negedge clk);
      a = 1'b0; b_ready = 1'b1;
      #2 rst = 1'b0;
      #1;
      check("mid_rst_b", {31'b0, b}, 0);
      check("mid_rst_backlog", {24'b0, backlog}, 0);
      check("mid_rst_overflow", {31'b0, overflow}, 0);
      m_owed = 0; m_ovf = 0;
      @(negedge clk);
      #1 rst = 1'b1;
      nb = 0;
      for (int i = 0; i < 5; i++) begin
         step(0, 1, bo);
         nb += int'(bo);
      end
      check("mid_after_count", nb, 0);

      // Random conservation, FACTOR=2.
      na = 0; nb = 0;
      for (int i = 0; i < 100; i++) begin
         logic av, brv;
         av  = logic'($urandom_range(0, 1));
         brv = ($urandom_range(0, 3) != 0);
         step(av, brv, bo);
         na += int'(av);
         nb += int'(bo);
      end
      for (int i = 0; i < 400; i++) begin
         step(0, 1, bo);
         nb += int'(bo);
      end
      check("rand2_conservation", nb, 2 * na);
      check("rand2_overflow", {31'b0, overflow}, 0);
      check("rand2_backlog", {24'b0, backlog}, 0);

      // Random conservation, FACTOR=3.
      na = 0; nb = 0;
      for (int i = 0; i < 100; i++) begin
         logic av, brv;
         av  = logic'($urandom_range(0, 1));
         brv = ($urandom_range(0, 3) != 0);
         step3(av, brv, bo);
         na += int'(av);
         nb += int'(bo);
      end
      for (int i = 0; i < 400; i++) begin
         step3(0, 1, bo);
         nb += int'(bo);
      end
      check("rand3_conservation", nb, 3 * na);
      check("rand3_overflow", {31'b0, overflow3}, 0);
      check("rand3_backlog", {24'b0, backlog3}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
